// File: rtl/andrewm_uart_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package andrewm_uart_pkg;

  // Transmitter FSM states, 2-bit encoded.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS     = 8;     // payload bits per frame
  localparam int   FRAME_BITS    = 10;    // start + 8 data + stop
  localparam logic IDLE_LEVEL    = 1'b1;  // line level when nothing is sent
  localparam int   NUM_REQ_FIXED = 4;     // requester count of this revision

  // Cycles between successive START edges when requests are back to back:
  // one full frame plus the single IDLE cycle between frames.
  function automatic int frame_period(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit + 1;
  endfunction

endpackage

// File: rtl/andrewm_uart_tx_arbiter_if.sv
// Requester/serial-side signal bundle of the UART transmit arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req level until ack; no other flow control.
interface andrewm_uart_tx_arbiter_if;
  import andrewm_uart_pkg::*;

  logic [NUM_REQ_FIXED-1:0]           req;
  logic [NUM_REQ_FIXED*DATA_BITS-1:0] req_data;
  logic [NUM_REQ_FIXED-1:0]           ack;
  logic                               uart_tx;
  logic                               busy;
  logic [1:0]                         grant_id;
  logic                               done;

  // Requester side (drives requests, observes the transmitter).
  modport master (
    output req, req_data,
    input  ack, uart_tx, busy, grant_id, done
  );

  // Transmitter side (the arbiter itself).
  modport slave (
    input  req, req_data,
    output ack, uart_tx, busy, grant_id, done
  );

endinterface

// File: rtl/andrewm_rr_arbiter4.sv
// Four-way round-robin picker: first requester after last_grant wins, wrapping 3->0.
// Latency: purely combinational.
// Backpressure: none; enable low forces an empty grant.
module andrewm_rr_arbiter4
  import andrewm_uart_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  input  logic       enable,
  output logic [3:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] cand;
  logic       found;

  // Scan the four positions starting just after the last grant; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ_FIXED; k++) begin
      cand = last_grant + k[1:0];
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/andrewm_uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter shared by four requesters.
// Latency: req seen in IDLE at edge N -> ack pulse and start bit from cycle N+1.
// Backpressure: requests are only sampled in IDLE; a requester waits, holding req, until acked.
module andrewm_uart_tx_arbiter
  import andrewm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 256,
  parameter int NUM_REQ      = 4
)
(
  input  logic                      clk,
  input  logic                      reset,
  andrewm_uart_tx_arbiter_if.slave  bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           gid_q, gid_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [NUM_REQ-1:0]   rr_grant;
  logic [1:0]           rr_idx;
  logic                 tx_c;
  logic                 done_c;

  // Only arbitrate while the line is free so requests during a frame are ignored.
  andrewm_rr_arbiter4 u_rr (
    .req        (bus.req),
    .last_grant (last_q),
    .enable     (state_q == IDLE),
    .grant      (rr_grant),
    .grant_idx  (rr_idx)
  );

  // State, baud counter, bit index, shift register, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 2'd3;   // requester 0 gets first pick after reset
      gid_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state, datapath updates and line/done outputs for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    gid_d   = gid_q;
    ack_d   = '0;
    tx_c    = IDLE_LEVEL;
    done_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          state_d = START;
          baud_d  = BAUD_LOAD;
          shift_d = bus.req_data[{rr_idx, 3'b000} +: DATA_BITS];
          ack_d   = rr_grant;
          gid_d   = rr_idx;
          last_d  = rr_idx;
        end
      end

      START: begin
        tx_c = 1'b0;
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      DATA: begin
        tx_c = shift_q[0];
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      STOP: begin
        tx_c = 1'b1;
        if (baud_q == '0) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.uart_tx  = tx_c;
  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = gid_q;
  assign bus.done     = done_c;

endmodule

// File: doc/andrewm_uart_tx_arbiter.md
ANDREWM_UART_TX_ARBITER -- requirements
Module: andrewm_uart_tx_arbiter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 256, clock cycles per UART bit; legal range 2..256.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-003 clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  4  per-requester request, level; bit i belongs to requester i.
REQ-006 req_data  input  32  byte i in bits [8i+7:8i], valid while req[i] is high.
REQ-007 ack  output  4  one-cycle pulse on bit i when requester i's byte is captured.
REQ-008 uart_tx  output  1  serial line, idle high, 8N1 format.
REQ-009 busy  output  1  high while a frame is on the line.
REQ-010 grant_id  output  2  index of the current or most recently granted requester.
REQ-011 done  output  1  one-cycle pulse in the final stop-bit cycle of each completed frame.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-013 In IDLE with req != 0, the block SHALL select one requester round-robin, capture its byte, and enter START on the next edge.
REQ-014 Round-robin order SHALL begin at the index after the last grant, wrapping 3->0; after reset the last grant is 3, so requester 0 has first priority.
REQ-015 ack[i] SHALL pulse in the first START cycle; grant_id SHALL update in that same cycle; at most one ack bit SHALL be high per cycle.
REQ-016 Latency: req seen in IDLE at edge N -> ack and uart_tx=0 from cycle N+1.
REQ-017 START SHALL hold uart_tx=0; DATA SHALL send captured bits LSB first; STOP SHALL hold uart_tx=1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-018 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, load CLKS_PER_BIT-1 at each bit start, and advance the bit on 0.
REQ-019 The data bit index SHALL be 3 bits, 0..7; DATA->STOP SHALL occur when index 7 expires; no wrap into a ninth bit.
REQ-020 After STOP the FSM SHALL spend exactly one cycle in IDLE (uart_tx=1) before the next START; back-to-back frame period = 10*CLKS_PER_BIT+1 cycles.
REQ-021 busy SHALL be high in START, DATA and STOP and low in IDLE.
REQ-022 req and req_data SHALL be ignored outside IDLE; changes after capture SHALL NOT affect the frame in flight.
REQ-023 A requester that drops req before being granted SHALL receive no ack and send no frame.
REQ-024 A requester holding req high after its ack SHALL be treated as a new request, subject to round-robin.
REQ-025 Simultaneous requests SHALL be resolved only by the round-robin pointer; no requester SHALL wait more than 3 frames.

Reset
REQ-026 While reset=0 at an edge, the next cycle SHALL show: uart_tx=1, busy=0, ack=0, done=0, grant_id=0, state IDLE, and the pointer giving requester 0 first priority.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; the aborted requester SHALL get no second ack.

Structure
REQ-028 Package andrewm_uart_pkg SHALL hold the FSM state enum (2-bit), the frame constants (DATA_BITS=8, FRAME_BITS=10) and the idle-level constant.
REQ-029 Round-robin selection SHALL live in sub-module andrewm_rr_arbiter4: inputs req, last-grant pointer, enable; outputs one-hot grant and encoded index; combinational only.
REQ-030 The FSM, baud counter, shift register and pointer register SHALL reside in andrewm_uart_tx_arbiter.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset low 2 cycles, req=4'hF -> uart_tx=1, busy=0, ack=0, done=0, grant_id=0 throughout reset.
REQ-032 req=4'b0010, byte1=0xA5 -> ack=4'b0010 for one cycle; uart_tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; done in cycle 40 of the frame.
REQ-033 req=4'hF held from reset release -> grants 0,1,2,3,0 with STARTs 41 cycles apart, one IDLE cycle between frames.
REQ-034 req=4'b0101 held -> grant_id sequence 0,2,0,2; requesters 1 and 3 never acked.
REQ-035 reset=0 for one cycle at cycle 15 of a frame -> uart_tx=1 the next cycle, no done, next grant goes to requester 0.
REQ-036 req[3] raised while busy and dropped before the frame ends -> no ack[3], no second frame.
